seg_shift_rx: RTL
=================

Name: seg_shift_rx

Overview:
- Receiver for the serial LED/seven-segment shift stream (clock, data, latch-enable) produced by the display driver.
- Oversamples the three lines in the `clk` domain and deserialises one frame per enable window.
- Presents each frame as a parallel word with a one-cycle valid pulse.
- Used as an on-board loopback checker for the display path and as a synthesizable bench monitor.

Parameters:
- FRAME_BITS, 64, bits per frame (8 digits x 8 segments).
- SYNC_STAGES, 2, synchronizer flops per serial input (min 2).
- MSB_FIRST, 1, 1: first received bit lands in frame_data[FRAME_BITS-1]; 0: lands in bit 0.
- CNT_W, 16, width of frame/error counters.

Ports:
- clk  input  1  sampling clock (25 MHz display clock).
- rstn  input  1  asynchronous active-low reset.
- sclk  input  1  serial shift clock, asynchronous to clk.
- sdo  input  1  serial data, valid at sclk rising edge.
- sen  input  1  frame enable, high for the whole shift window, asynchronous.
- frame_data  output  FRAME_BITS  last complete frame.
- frame_valid  output  1  one-cycle pulse when frame_data updates.
- frame_err  output  1  one-cycle pulse on a malformed frame.
- frame_cnt  output  CNT_W  good frames received, wraps.
- err_cnt  output  CNT_W  bad frames, saturates at all-ones.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (rstn=0, async): all outputs 0, state IDLE, shift register and bit counter 0, synchronizer flops 0.
- Synchronisation and edge detect:
  - sclk, sen, sdo each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized sclk and sen.
  - sdo is sampled from the same synchronized stage as sclk, so both see equal delay.
- Timing requirement: sclk high and low phases each ≥ SYNC_STAGES+1 clk periods. Violations are not detected.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - sen rising -> SHIFT; clear bit counter and overrun flag.
  - sclk edges are ignored.
- SHIFT:
  - Each sclk rising edge shifts sdo into the shift register, direction per MSB_FIRST, and increments the bit counter.
  - When the counter is at FRAME_BITS, a further edge sets overrun; the counter saturates and that bit is discarded.
  - sen falling -> DONE.
- Same-cycle sclk rise and sen fall: the bit is shifted first, then the transition is taken.
- DONE (exactly one cycle), then -> IDLE:
  - If counter==FRAME_BITS and no overrun: frame_data <= shift register, frame_valid=1, frame_cnt+1 (wraps).
  - Otherwise: frame_err=1, err_cnt+1 (saturates); frame_data unchanged.
- Latency: frame_valid/frame_err is asserted SYNC_STAGES+2 clk cycles after sen falls at the pin.
- sen rising while in DONE: captured and acted on in the following IDLE cycle, so back-to-back frames are not lost.
- busy = (state==SHIFT).
- Reset mid-frame: the partial frame is dropped and no pulse is generated. After release, wait for the next sen rising.

Optional Feature:
- SEGRX_GLITCH_FILTER_EN defined:
  - Synchronized sclk and sen each pass through a 3-sample agreement filter; the output changes only when 3 consecutive samples agree.
  - Adds 2 cycles of latency.
  - Minimum phase requirement becomes SYNC_STAGES+3.
- Not defined: no filter, and the latency is as stated above.

Decomposition:
- Package seg_rx_pkg holds:
  - state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - default FRAME_BITS;
  - a function computing counter width, clog2(FRAME_BITS+1).
- Sub-module seg_rx_sync_edge:
  - SYNC_STAGES synchronizer, plus the optional filter, plus rise/fall pulse outputs;
  - instantiated for sclk and sen;
  - sdo uses only the delay chain.

Test Plan:
- Reset, then send 64 bits 0x0123_4567_89AB_CDEF MSB-first, sclk period 8 clk -> frame_data=0x0123456789ABCDEF, one frame_valid pulse, frame_cnt=1, err_cnt=0.
- Send 63 bits, then drop sen -> frame_err pulse, err_cnt=1, frame_data keeps its previous value, no frame_valid.
- Send 65 bits -> frame_err pulse, err_cnt+1; a following good 64-bit frame 0xFFFF_0000_FFFF_0000 -> valid pulse with that value.
- Two frames with sen low for only 1 sclk period between them (0xAAAA… then 0x5555…) -> two valid pulses, values in order, frame_cnt=2.
- Pull rstn low at bit 30, release, send a good frame 0x1 -> no pulse during reset, all outputs 0 during reset, then frame_data=0x1 and frame_cnt=1.
- With SEGRX_GLITCH_FILTER_EN defined, inject 1-cycle sclk glitches during a 64-bit frame -> correct frame, no error, frame_valid asserted 2 cycles later than in the unfiltered build.

Source files
------------

// File: rtl/seg_rx_pkg.sv
// rtl/seg_rx_pkg.sv - shared state encoding, default frame size and counter width helper for seg_shift_rx
package seg_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seg_rx_state_e;

  localparam int SEG_RX_FRAME_BITS = 64;

  // Bit counter must hold FRAME_BITS itself, not just FRAME_BITS-1.
  function automatic int seg_rx_cnt_w(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/seg_rx_sync_edge.sv
// rtl/seg_rx_sync_edge.sv - synchronizer with rise/fall pulses; SEGRX_GLITCH_FILTER_EN adds a 3-sample agreement filter
module seg_rx_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              synced;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign synced = sync_q[STAGES-1];

`ifdef SEGRX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       filt_d;

  // The filtered level moves only once the current and two previous samples agree.
  always_comb begin
    filt_d = filt_q;
    if ((synced == hist_q[0]) && (synced == hist_q[1])) begin
      filt_d = synced;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], synced};
      filt_q <= filt_d;
    end
  end

  assign level_o = filt_d;
  assign rise_o  = filt_d & ~filt_q;
  assign fall_o  = ~filt_d & filt_q;
`else
  logic prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= synced;
    end
  end

  assign level_o = synced;
  assign rise_o  = synced & ~prev_q;
  assign fall_o  = ~synced & prev_q;
`endif

endmodule

// File: rtl/seg_shift_rx.sv
// rtl/seg_shift_rx.sv - serial LED/segment shift stream receiver; optional SEGRX_GLITCH_FILTER_EN filters sclk/sen
module seg_shift_rx
  import seg_rx_pkg::*;
#(
  parameter int FRAME_BITS  = SEG_RX_FRAME_BITS,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sclk,
  input  logic                  sdo,
  input  logic                  sen,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  busy
);

  localparam int BIT_W = seg_rx_cnt_w(FRAME_BITS);
`ifdef SEGRX_GLITCH_FILTER_EN
  localparam int SDO_STAGES = SYNC_STAGES + 2;
`else
  localparam int SDO_STAGES = SYNC_STAGES;
`endif

  logic                  sclk_rise;
  logic                  sclk_fall_unused;
  logic                  sclk_level_unused;
  logic                  sen_rise;
  logic                  sen_fall;
  logic                  sen_level_unused;
  logic [SDO_STAGES-1:0] sdo_q;
  logic                  sdo_s;
  logic [FRAME_BITS-1:0] shift_d;

  seg_rx_state_e         state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  ovr_q;
  logic                  pend_q;
  logic [FRAME_BITS-1:0] frame_data_q;
  logic                  frame_valid_q;
  logic                  frame_err_q;
  logic [CNT_W-1:0]      frame_cnt_q;
  logic [CNT_W-1:0]      err_cnt_q;

  seg_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk     (clk),
    .rstn    (rstn),
    .d_i     (sclk),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall_unused)
  );

  seg_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sen_sync (
    .clk     (clk),
    .rstn    (rstn),
    .d_i     (sen),
    .level_o (sen_level_unused),
    .rise_o  (sen_rise),
    .fall_o  (sen_fall)
  );

  // sdo is delayed exactly as far as the sclk edge so the sampled bit lines up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sdo_q <= '0;
    end else begin
      sdo_q <= {sdo_q[SDO_STAGES-2:0], sdo};
    end
  end

  assign sdo_s = sdo_q[SDO_STAGES-1];

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_d = {shift_q[FRAME_BITS-2:0], sdo_s};
    end else begin : g_lsb_first
      assign shift_d = {sdo_s, shift_q[FRAME_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      ovr_q         <= 1'b0;
      pend_q        <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sen_rise || pend_q) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            ovr_q     <= 1'b0;
            pend_q    <= 1'b0;
          end
        end
        SHIFT: begin
          // A same-cycle sclk rise is still taken before leaving on sen fall.
          if (sclk_rise) begin
            if (bit_cnt_q == BIT_W'(FRAME_BITS)) begin
              ovr_q <= 1'b1;
            end else begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
          if (sen_fall) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          pend_q  <= sen_rise;
          if ((bit_cnt_q == BIT_W'(FRAME_BITS)) && !ovr_q) begin
            frame_data_q  <= shift_q;
            frame_valid_q <= 1'b1;
            frame_cnt_q   <= frame_cnt_q + CNT_W'(1);
          end else begin
            frame_err_q <= 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
              err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = (state_q == SHIFT);

endmodule
